// File: rtl/pipe_rr_sched_if.sv
// Request/response bundle for pipe_rr_sched.
//   req_valid/req_last/req_data : per-requester beats (requester i at data bits [i*WIDTH +: WIDTH])
//   req_ready                   : per-requester accept, at most one bit high
//   stall                       : freezes pipeline and arbitration
//   out_valid/out_data/out_id   : beat leaving the last pipeline stage with its requester index
//   busy                        : burst lock held or any stage occupied
// The master modport belongs to the requester side, the slave modport to the scheduler.
`timescale 1ns/1ps
interface pipe_rr_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  stall;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  busy;

  modport master (
    output req_valid, req_last, req_data, stall,
    input  req_ready, out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, stall,
    output req_ready, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler feeding a shared fixed-latency register pipeline.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pipe_rr_sched_if.slave (requests in, req_ready/out_*/busy out)
// In IDLE the grant goes to the first valid requester at or above ptr (wrapping). A non-last
// beat locks the grant to that requester (BURST) until it sends last or MAXBURST beats.
// Accepted beats are tagged with the requester index and leave after LAT register stages.
`timescale 1ns/1ps
module pipe_rr_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LAT      = 3,
  parameter int unsigned MAXBURST = 4
) (
  input logic             clk,
  input logic             rst,
  pipe_rr_sched_if.slave  bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(MAXBURST + 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [LAT-1:0]   vld_q;
  logic [WIDTH-1:0] data_q [LAT];
  logic [IDW-1:0]   id_q   [LAT];

  logic [IDW-1:0]   grant_idx;
  logic             grant_ok;
  logic [IDW-1:0]   scan_idx;
  logic [NREQ-1:0]  ready;
  logic             accept;
  logic             acc_last;
  logic [WIDTH-1:0] acc_data;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    return (int'(i) == int'(NREQ) - 1) ? '0 : i + 1'b1;
  endfunction

  // Grant selection. The IDLE scan runs from the farthest candidate back to ptr so the
  // nearest valid requester is written last and wins without needing a break.
  always_comb begin
    grant_idx = '0;
    grant_ok  = 1'b0;
    scan_idx  = '0;
    if (state_q == StBurst) begin
      grant_idx = owner_q;
      grant_ok  = bus.req_valid[owner_q];
    end else begin
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
        scan_idx = IDW'((int'(ptr_q) + k) % int'(NREQ));
        if (bus.req_valid[scan_idx]) begin
          grant_idx = scan_idx;
          grant_ok  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant_ok && !bus.stall && !rst) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign bus.req_ready = ready;
  assign accept        = |ready;
  assign acc_last      = bus.req_last[grant_idx];

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_idx == IDW'(i)) begin
        acc_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic. accept is already low under stall.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (acc_last || (MAXBURST == 1)) begin
            ptr_d = wrap_inc(grant_idx);
          end else begin
            state_d = StBurst;
            owner_d = grant_idx;
            cnt_d   = CW'(1);
          end
        end
      end
      StBurst: begin
        if (accept) begin
          if (acc_last || (int'(cnt_q) + 1 == int'(MAXBURST))) begin
            state_d = StIdle;
            ptr_d   = wrap_inc(owner_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pipeline: only the valid bit follows bubbles; data/id of an empty slot keep their old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        data_q[k] <= '0;
        id_q[k]   <= '0;
      end
    end else if (!bus.stall) begin
      vld_q[0] <= accept;
      if (accept) begin
        data_q[0] <= acc_data;
        id_q[0]   <= grant_idx;
      end
      for (int k = 1; k < int'(LAT); k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          data_q[k] <= data_q[k-1];
          id_q[k]   <= id_q[k-1];
        end
      end
    end
  end

  assign bus.out_valid = vld_q[LAT-1];
  assign bus.out_data  = data_q[LAT-1];
  assign bus.out_id    = id_q[LAT-1];
  assign bus.busy      = (state_q == StBurst) || (|vld_q);

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Directed testbench for pipe_rr_sched (NREQ=4, WIDTH=8, LAT=3, MAXBURST=4).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after that.
`timescale 1ns/1ps
module tb_pipe_rr_sched;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned LAT      = 3;
  localparam int unsigned MAXBURST = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  pipe_rr_sched #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .LAT     (LAT),
    .MAXBURST(MAXBURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.stall     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.stall     = 1'b0;
    bus.req_data  = 32'h13121110;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++;
      $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    checks++; if (bus.out_id !== 2'd0) begin failures++;
      $display("FAIL reset_out_id got=%0d exp=0", bus.out_id); end
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++;
      $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    idle_inputs();
    rst = 1'b0;
    #1;
  endtask

  // Requester 2 sends one beat; it exits on the third edge counting the accepting edge.
  task automatic test_single();
    bus.req_data  = 32'h00A50000;
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++;
      $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    tick();
    idle_inputs();
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL single_early1 got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL single_early2 got=%b exp=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_id !== 2'd2) begin
      failures++;
      $display("FAIL single_out got=%b/%h/%0d exp=1/a5/2", bus.out_valid, bus.out_data,
               bus.out_id); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL single_pulse got=%b exp=0", bus.out_valid); end
    // ptr should now be 3
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++;
      $display("FAIL single_ptr got=%b exp=1000", bus.req_ready); end
    idle_inputs();
    #1;
  endtask

  task automatic test_rr();
    logic [3:0] exp_ready;
    logic       exp_v;
    logic [1:0] exp_id;
    do_reset();
    bus.req_data = 32'h13121110;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        #1;
        exp_ready = 4'b0001 << (k % 4);
        checks++; if (bus.req_ready !== exp_ready) begin failures++;
          $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_ready); end
      end else begin
        idle_inputs();
      end
      tick();
      exp_v  = (k >= 2);
      exp_id = 2'((k - 2) % 4);
      checks++;
      if (bus.out_valid !== exp_v || (exp_v && (bus.out_id !== exp_id ||
          bus.out_data !== (8'h10 + 8'(exp_id))))) begin
        failures++;
        $display("FAIL rr_out[%0d] got=%b/%0d/%h exp=%b/%0d/%h", k, bus.out_valid, bus.out_id,
                 bus.out_data, exp_v, exp_id, 8'h10 + 8'(exp_id));
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  // Requester 1 bursts with last=0 while the others send single beats.
  task automatic test_burst();
    logic [3:0] exp_ready [9];
    exp_ready = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                  4'b0010, 4'b0010};
    do_reset();
    bus.req_data = 32'h13121110;
    bus.req_last = 4'b1101;
    for (int k = 0; k < 9; k++) begin
      bus.req_valid = (k == 0) ? 4'b0010 : 4'b1111;
      #1;
      checks++; if (bus.req_ready !== exp_ready[k]) begin failures++;
        $display("FAIL burst_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_ready[k]); end
      tick();
      if (k == 0) begin
        checks++; if (bus.busy !== 1'b1) begin failures++;
          $display("FAIL burst_busy got=%b exp=1", bus.busy); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [3:0] in_valid [8];
    logic       in_stall [8];
    logic [7:0] in_data  [8];
    logic [3:0] exp_rdy  [8];
    logic       exp_v    [8];
    logic [7:0] exp_d    [8];
    in_valid = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    in_stall = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    in_data  = '{8'h31, 8'h32, 8'h33, 8'h44, 8'h44, 8'h00, 8'h00, 8'h00};
    exp_rdy  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    exp_v    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d    = '{8'h00, 8'h00, 8'h31, 8'h31, 8'h31, 8'h32, 8'h33, 8'h33};
    do_reset();
    bus.req_last = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      bus.req_valid = in_valid[k];
      bus.stall     = in_stall[k];
      bus.req_data  = {24'h0, in_data[k]};
      #1;
      checks++; if (bus.req_ready !== exp_rdy[k]) begin failures++;
        $display("FAIL stall_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_rdy[k]); end
      tick();
      checks++; if (bus.out_valid !== exp_v[k] || bus.out_data !== exp_d[k]) begin failures++;
        $display("FAIL stall_out[%0d] got=%b/%h exp=%b/%h", k, bus.out_valid, bus.out_data,
                 exp_v[k], exp_d[k]); end
    end
    idle_inputs();
  endtask

  // Owner 0 drops valid mid-burst; requester 3 must wait for the owner's last beat.
  task automatic test_owner_drop();
    logic [3:0] in_valid [5];
    logic [3:0] in_last  [5];
    logic [3:0] exp_rdy  [5];
    in_valid = '{4'b0001, 4'b1000, 4'b1000, 4'b1001, 4'b1000};
    in_last  = '{4'b0000, 4'b1000, 4'b1000, 4'b1001, 4'b1000};
    exp_rdy  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b1000};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = in_valid[k];
      bus.req_last  = in_last[k];
      #1;
      checks++; if (bus.req_ready !== exp_rdy[k]) begin failures++;
        $display("FAIL drop_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_rdy[k]); end
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_data  = 32'h13121110;
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0000;
    for (int k = 0; k < 3; k++) tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_full got=%b/%0d/%b exp=1/1/1", bus.out_valid, bus.out_id, bus.busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_rst_out got=%b/%h/%0d exp=0/00/0", bus.out_valid, bus.out_data,
               bus.out_id); end
    checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin failures++;
      $display("FAIL mid_rst_ctrl got=%b/%b exp=0/0000", bus.busy, bus.req_ready); end
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++;
      $display("FAIL mid_first_grant got=%b exp=0001", bus.req_ready); end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++;
        $display("FAIL mid_ghost[%0d] got=%b exp=0", k, bus.out_valid); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req_data = '0;
    idle_inputs();
    test_reset();
    test_single();
    test_rr();
    test_burst();
    test_stall();
    test_owner_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
